// File: rtl/trace_capture_if.sv
// Record stream between trace_capture (master) and a trace consumer (slave).
interface trace_capture_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_pc;
  logic [31:0] rec_instr;
  logic [31:0] rec_data;
  logic [1:0]  rec_kind;
  logic [3:0]  rec_flags;
  logic [15:0] rec_seq;

  modport master (
    output rec_valid, rec_pc, rec_instr, rec_data, rec_kind, rec_flags, rec_seq,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_pc, rec_instr, rec_data, rec_kind, rec_flags, rec_seq,
    output rec_ready
  );
endinterface

// File: rtl/trace_capture.sv
// Core execution trace capture: arms on enable, triggers on a PC match and buffers
// per-cycle records in a FIFO drained through a valid/ready stream.
module trace_capture #(
  parameter int unsigned DEPTH        = 16,
  parameter bit          STOP_ON_FULL = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic [31:0]             trig_pc_i,
  input  logic [7:0]              stop_cnt_i,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             instr_i,
  input  logic [31:0]             result_i,
  input  logic [31:0]             wdata_i,
  input  logic                    memwrite_i,
  input  logic                    regwrite_i,
  input  logic                    pcsrc_i,
  input  logic [3:0]              flags_i,
  trace_capture_if.master         rec,
  output logic [1:0]              state_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [7:0]              ovf_cnt_o,
  output logic                    ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 118;

  localparam logic [1:0] StIdle    = 2'b00;
  localparam logic [1:0] StArmed   = 2'b01;
  localparam logic [1:0] StCapture = 2'b10;
  localparam logic [1:0] StStopped = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [15:0]   seq_q, seq_d;
  logic [7:0]    cap_cnt_q, cap_cnt_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    ovf_cnt_q;
  logic          ovf_q;
  logic [RW-1:0] mem_q [DEPTH];

  logic          capture, push, pop, drop, full, empty;
  logic [1:0]    kind;
  logic [7:0]    cap_cnt_inc;
  logic [RW-1:0] wrec;

  assign empty       = (count_q == '0);
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign pop         = !empty && rec.rec_ready;
  assign capture     = en_i && ((state_q == StArmed && pc_i == trig_pc_i) || state_q == StCapture);
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign push        = capture && (!full || pop);
  assign drop        = capture && full && !pop;
  assign cap_cnt_inc = cap_cnt_q + 8'd1;

  always_comb begin
    kind = 2'b00;
    if (memwrite_i)      kind = 2'b10;
    else if (pcsrc_i)    kind = 2'b11;
    else if (regwrite_i) kind = 2'b01;
  end

  assign wrec = {pc_i, instr_i, (memwrite_i ? wdata_i : result_i), kind, flags_i, seq_q};

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    cap_cnt_d = cap_cnt_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d   = StArmed;
          seq_d     = '0;
          cap_cnt_d = '0;
        end
        StArmed, StCapture: begin
          seq_d = seq_q + 16'd1;
          if (capture) begin
            cap_cnt_d = cap_cnt_inc;
            if ((stop_cnt_i != 8'd0 && cap_cnt_inc == stop_cnt_i) || (STOP_ON_FULL && drop)) begin
              state_d = StStopped;
            end else begin
              state_d = StCapture;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      seq_q     <= '0;
      cap_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      cap_cnt_q <= cap_cnt_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end

  // Storage needs no reset: the read side is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wptr_q] <= wrec;
  end

  assign rec.rec_valid = !empty;
  assign {rec.rec_pc, rec.rec_instr, rec.rec_data, rec.rec_kind, rec.rec_flags, rec.rec_seq} =
      empty ? '0 : mem_q[rptr_q];

  assign state_o   = state_q;
  assign count_o   = count_q;
  assign ovf_cnt_o = ovf_cnt_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: directed scenarios plus random traffic against a queue model.
module tb_trace_capture;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, memw, regw, pcsrc;
  logic [31:0]   trig_pc, pc, instr, result, wdata;
  logic [7:0]    stop_cnt;
  logic [3:0]    flags;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [7:0]    ovf_cnt;
  logic          ovf;

  trace_capture_if rif ();

  trace_capture #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en),
    .trig_pc_i  (trig_pc),
    .stop_cnt_i (stop_cnt),
    .pc_i       (pc),
    .instr_i    (instr),
    .result_i   (result),
    .wdata_i    (wdata),
    .memwrite_i (memw),
    .regwrite_i (regw),
    .pcsrc_i    (pcsrc),
    .flags_i    (flags),
    .rec        (rif),
    .state_o    (state),
    .count_o    (count),
    .ovf_cnt_o  (ovf_cnt),
    .ovf_o      (ovf)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [1:0]  kind;
    logic [3:0]  flags;
    logic [15:0] seq;
  } rec_t;

  // Reference model: 0 idle, 1 armed, 2 capture, 3 stopped.
  rec_t q[$];
  int   m_state, m_seq, m_cap, m_ovf_cnt;
  bit   m_ovf;
  int   n_assert, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic core(input logic [31:0] p);
    pc     = p;
    instr  = $urandom;
    result = $urandom;
    wdata  = $urandom;
    flags  = 4'($urandom);
    memw   = 1'($urandom);
    regw   = 1'($urandom);
    pcsrc  = 1'($urandom);
  endtask

  task automatic model_edge();
    rec_t r;
    bit   pop, cap;
    if (!reset) begin
      q.delete();
      m_state = 0; m_seq = 0; m_cap = 0; m_ovf = 0; m_ovf_cnt = 0;
      return;
    end
    pop     = (q.size() > 0) && rif.rec_ready;
    cap     = en && ((m_state == 1 && pc == trig_pc) || m_state == 2);
    r.pc    = pc;
    r.instr = instr;
    r.data  = memw ? wdata : result;
    r.kind  = memw ? 2'b10 : pcsrc ? 2'b11 : regw ? 2'b01 : 2'b00;
    r.flags = flags;
    r.seq   = m_seq[15:0];
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_ovf_cnt < 255) m_ovf_cnt++;
      end
    end
    if (!en) m_state = 0;
    else if (m_state == 0) begin
      m_state = 1; m_seq = 0; m_cap = 0;
    end else if (m_state != 3) begin
      m_seq = (m_seq + 1) % 65536;
      if (cap) begin
        m_cap   = (m_cap + 1) % 256;
        m_state = (stop_cnt != 0 && m_cap == stop_cnt) ? 3 : 2;
      end
    end
  endtask

  task automatic compare_all();
    rec_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("state", state, m_state[1:0]);
    chk("count", count, q.size());
    chk("ovf", ovf, m_ovf);
    chk("ovf_cnt", ovf_cnt, m_ovf_cnt);
    chk("rec_valid", rif.rec_valid, q.size() > 0);
    chk("rec_pc", rif.rec_pc, h.pc);
    chk("rec_instr", rif.rec_instr, h.instr);
    chk("rec_data", rif.rec_data, h.data);
    chk("rec_kind", rif.rec_kind, h.kind);
    chk("rec_flags", rif.rec_flags, h.flags);
    chk("rec_seq", rif.rec_seq, h.seq);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drain();
    en = 1'b0;
    rif.rec_ready = 1'b1;
    repeat (DEPTH + 2) begin
      core(32'h0);
      step();
    end
    chk("drain_empty", count, 0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    reset = 1'b0; en = 1'b0; trig_pc = '0; stop_cnt = '0; rif.rec_ready = 1'b0;
    core(32'h0);
    step();
    chk("rst_state", state, 2'b00);
    chk("rst_valid", rif.rec_valid, 1'b0);
    reset = 1'b1;

    // Trigger at PC 0x8 after two armed cycles.
    en = 1'b1; trig_pc = 32'h8; rif.rec_ready = 1'b1;
    core(32'h0); step();
    chk("armed", state, 2'b01);
    core(32'h0); step();
    core(32'h4); step();
    core(32'h8); step();
    chk("trig_pc", rif.rec_pc, 32'h8);
    chk("trig_seq", rif.rec_seq, 16'd2);
    core(32'hC); step();
    chk("next_pc", rif.rec_pc, 32'hC);
    chk("next_seq", rif.rec_seq, 16'd3);

    // Memory write outranks a taken branch.
    core(32'h10); memw = 1'b1; wdata = 32'h7; result = 32'h64; pcsrc = 1'b1;
    step();
    chk("kind_mem", rif.rec_kind, 2'b10);
    chk("data_mem", rif.rec_data, 32'h7);

    // Overflow: 20 captures into 16 slots, then ordered drain.
    drain();
    rif.rec_ready = 1'b0; en = 1'b1; trig_pc = 32'h100;
    core(32'h0); step();
    for (int i = 0; i < 20; i++) begin
      core(32'h100 + 4 * i); step();
    end
    chk("full_count", count, 16);
    chk("full_ovf", ovf, 1'b1);
    chk("full_ovf_cnt", ovf_cnt, 8'd4);
    en = 1'b0; core(32'h0); step();
    rif.rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_pc", rif.rec_pc, 32'h100 + 4 * i);
      core(32'h0); step();
    end
    chk("drained", count, 0);

    // Full FIFO with concurrent pops keeps capturing without drops.
    en = 1'b1; rif.rec_ready = 1'b0; trig_pc = 32'h200;
    core(32'h0); step();
    for (int i = 0; i < 16; i++) begin
      core(32'h200 + 4 * i); step();
    end
    chk("fill_count", count, 16);
    rif.rec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core(32'h300 + 4 * i); step();
    end
    chk("flow_count", count, 16);
    chk("flow_ovf_cnt", ovf_cnt, 8'd4);

    // Stop after three records, then re-arm and check the sequence restart.
    drain();
    stop_cnt = 8'd3; en = 1'b1; rif.rec_ready = 1'b0; trig_pc = 32'h300;
    core(32'h0); step();
    for (int i = 0; i < 6; i++) begin
      core(32'h300 + 4 * i); step();
    end
    chk("stop_count", count, 3);
    chk("stop_state", state, 2'b11);
    drain();
    en = 1'b1; trig_pc = 32'h400;
    core(32'h0); step();
    chk("rearm_state", state, 2'b01);
    core(32'h400); step();
    chk("rearm_seq", rif.rec_seq, 16'd0);
    stop_cnt = 8'd0;

    // Reset with five records held.
    drain();
    en = 1'b1; rif.rec_ready = 1'b0; trig_pc = 32'h500;
    core(32'h0); step();
    for (int i = 0; i < 5; i++) begin
      core(32'h500 + 4 * i); step();
    end
    chk("pre_rst_count", count, 5);
    reset = 1'b0; core(32'h504); step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rif.rec_valid, 1'b0);
    chk("mid_rst_state", state, 2'b00);
    reset = 1'b1;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      int ready_pct;
      ready_pct = (i / 100) % 2 == 0 ? 30 : 80;
      reset = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 29) != 0);
      if (m_state == 0) begin
        trig_pc  = 32'($urandom_range(0, 7)) << 2;
        stop_cnt = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 20)) : 8'd0;
      end
      rif.rec_ready = ($urandom_range(0, 99) < ready_pct);
      core(32'($urandom_range(0, 7)) << 2);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, 16, FIFO record slots; power of two, 4..64.
REQ-002 Parameter STOP_ON_FULL, 0, 1 = enter STOPPED on first dropped record; 0 = keep capturing and count drops.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low.
REQ-005 en  in  1  capture enable; low forces IDLE.
REQ-006 trig_pc  in  32  PC value that starts capture.
REQ-007 stop_cnt  in  8  records to capture before STOPPED; 0 = unlimited.
REQ-008 pc_in, instr_in, result_in, wdata_in  in  32 each  per-cycle core state: PC, Instr, ALUResult, WriteData.
REQ-009 memwrite_in, regwrite_in, pcsrc_in  in  1 each  core MemWrite, RegWrite, PCSrc.
REQ-010 flags_in  in  4  core {N,Z,C,V}.
REQ-011 rec_valid  out  1  head record available.
REQ-012 rec_ready  in  1  consumer accepts head record.
REQ-013 rec_pc, rec_instr, rec_data  out  32 each  head record fields.
REQ-014 rec_kind  out  2  00 other, 01 reg write, 10 mem write, 11 taken branch.
REQ-015 rec_flags  out  4; rec_seq  out  16  head record flags and cycle index.
REQ-016 state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 STOPPED.
REQ-017 count  out  log2(DEPTH)+1  records held; ovf_cnt  out  8  dropped records; ovf  out  1  sticky drop flag.

Function
REQ-018 IDLE -> ARMED on rising clock with en=1.
REQ-019 ARMED -> CAPTURE when pc_in == trig_pc; the triggering cycle is captured.
REQ-020 CAPTURE -> STOPPED when captured-record count reaches stop_cnt (stop_cnt != 0), or on a drop when STOP_ON_FULL=1.
REQ-021 en=0 in any state -> IDLE next cycle; FIFO contents and ovf_cnt are retained and remain drainable.
REQ-022 STOPPED persists until en=0; no further captures.
REQ-023 In CAPTURE, one record is pushed per cycle; fields pc_in, instr_in, flags_in, and rec_data = wdata_in if memwrite_in else result_in.
REQ-024 rec_kind priority: memwrite_in (10) > pcsrc_in (11) > regwrite_in (01) > 00.
REQ-025 rec_seq = 16-bit cycle counter, cleared on IDLE->ARMED, +1 each cycle in ARMED/CAPTURE, wraps FFFF->0000.
REQ-026 Capture-to-output latency: record pushed at edge N appears on rec_* with rec_valid=1 after edge N when the FIFO was empty.
REQ-027 Pop occurs on an edge with rec_valid=1 and rec_ready=1; rec_* stable while rec_valid=1 and rec_ready=0.
REQ-028 Push and pop on the same edge: accepted even when full; count unchanged.
REQ-029 Push while full without pop: record dropped, ovf set, ovf_cnt +1 saturating at 255.
REQ-030 rec_ready with rec_valid=0: no effect; count never below 0.
REQ-031 Read/write pointers wrap modulo DEPTH.

Reset
REQ-032 reset=0 at rising edge: state=IDLE, FIFO empty, count=0, rec_valid=0, rec_* =0, rec_seq=0, ovf=0, ovf_cnt=0, capture counter=0.
REQ-033 Reset mid-CAPTURE or mid-drain discards all records with no partial record visible after the edge.

Verification
REQ-034 en=1, trig_pc=0x8, pc_in 0x0,0x4,0x8,0xC, rec_ready=1 -> first record rec_pc=0x8, rec_seq=2, then 0xC with seq=3.
REQ-035 CAPTURE, memwrite_in=1, wdata_in=0x7, result_in=0x64, pcsrc_in=1 -> rec_kind=10, rec_data=0x7.
REQ-036 DEPTH=16, rec_ready=0, 20 capture cycles -> count=16, ovf=1, ovf_cnt=4; drain yields the first 16 records in order.
REQ-037 Full FIFO, rec_ready=1 during capture -> no drops, count stays 16.
REQ-038 stop_cnt=3 -> exactly 3 records, state=STOPPED; en=0 then 1 -> ARMED, rec_seq restarts at 0.
REQ-039 reset=0 for one cycle with count=5 during capture -> next cycle count=0, rec_valid=0, state=IDLE.
